// File: rtl/timer_counter_if.sv
// timer_counter_if: CPU data-bus port of the countdown timer (word address, byte-enabled write, combinational read).
interface timer_counter_if;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output addr, we, byteen, wdata, input rdata);
    modport slave  (input addr, we, byteen, wdata, output rdata);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer (CTRL/PRESET/COUNT/PRESCALE) with masked irq.
// Optional feature TIMER_PRESCALE_EN adds the PRESCALE register and a per-tick prescaler.
module timer_counter #(
    parameter int PRESCALE_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus,
    output logic           irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t                state_q, state_d;
    logic [3:0]            ctrl_q, ctrl_d, ctrl_base;
    logic [31:0]           preset_q, preset_d, count_q, count_d, mask;
    logic                  irq_flag_q, irq_flag_d;
    logic                  en, auto_reload, ctrl_wr, tick;
    logic [PRESCALE_W-1:0] prescale_rd;
    assign mask        = {{8{bus.byteen[3]}}, {8{bus.byteen[2]}}, {8{bus.byteen[1]}}, {8{bus.byteen[0]}}};
    assign en          = ctrl_q[0];
    assign auto_reload = ctrl_q[2:1] == 2'b01;
    assign ctrl_wr     = bus.we && bus.addr == 2'd0 && |bus.byteen;
`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d, psc_q, psc_d;
    // A tick fires on the first CNT cycle after LOAD and then every PRESCALE+1 cycles.
    assign tick        = psc_q == '0;
    assign prescale_rd = prescale_q;
    always_comb begin
        prescale_d = (bus.we && bus.addr == 2'd3) ?
                     (prescale_q & ~mask[PRESCALE_W-1:0]) | (bus.wdata[PRESCALE_W-1:0] & mask[PRESCALE_W-1:0]) :
                     prescale_q;
        psc_d = (state_q == LOAD || state_q == INT) ? '0 :
                (state_q == CNT && en) ? (psc_q == prescale_q ? '0 : psc_q + 1'b1) : psc_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= '0;
            psc_q      <= '0;
        end else begin
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
        end
    end
`else
    assign tick        = 1'b1;
    assign prescale_rd = '0;
`endif
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ctrl_base  = ctrl_q;
        irq_flag_d = irq_flag_q & ~(auto_reload | ctrl_wr);
        case (state_q)
            IDLE: state_d = en ? LOAD : IDLE;
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en)
                    state_d = IDLE;
                else if (tick && count_q == 32'd0)
                    state_d = INT;
                else if (tick)
                    count_d = count_q - 32'd1;
            end
            INT: begin
                // Setting the flag takes priority over a same-cycle CTRL write clearing it.
                irq_flag_d   = 1'b1;
                state_d      = auto_reload ? LOAD : IDLE;
                ctrl_base[0] = auto_reload;
            end
            default: state_d = IDLE;
        endcase
        ctrl_d   = ctrl_wr ? (ctrl_base & ~mask[3:0]) | (bus.wdata[3:0] & mask[3:0]) : ctrl_base;
        preset_d = (bus.we && bus.addr == 2'd1) ? (preset_q & ~mask) | (bus.wdata & mask) : preset_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end
    always_comb begin
        bus.rdata = bus.addr == 2'd0 ? {28'd0, ctrl_q} :
                    bus.addr == 2'd1 ? preset_q :
                    bus.addr == 2'd2 ? count_q : 32'(prescale_rd);
    end
    assign irq = irq_flag_q & ctrl_q[3];
endmodule
